u_sequencer: RTL and testbench
==============================

Name: u_sequencer

Overview:
- Parametrised microcode sequencer: holds the micro-address, presents it to the microcode ROM, and registers the returned control word.
- Computes the next micro-address from the typ, offset, cond and escape fields in the low two control-word bytes: sequential offset, conditional branch, return to fetch, and opcode dispatch with escape page and IRQ intercept.
- Sits between the IR/flag logic and the control-word consumers; replaces hard-wired 14-byte next-address logic.

Parameters:
- CW_BYTES, 14, control-word width in bytes; must be >= 2.
- OPC_W, 8, opcode width.
- CYC_W, 6, log2 of micro-words per opcode.
- STACK_DEPTH, 4, return-stack entries (optional feature only).
- FETCH_ADDR, 0, fetch routine address; also the reset address.
- IRQ_ADDR, 'h7FC0, interrupt entry address.
- Localparam UADDR_W = 1 + OPC_W + CYC_W (default 15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold all state (memory wait)
- opcode  in  OPC_W  current IR opcode
- cond_cpu  in  16  CPU-flag condition vector
- cond_u  in  16  micro-flag condition vector
- irq_req  in  1  pending interrupt
- irq_en  in  1  status irq enable
- uaddr  out  UADDR_W  registered ROM address
- rom_data  in  8*CW_BYTES  combinational ROM word at uaddr
- cw_out  out  8*CW_BYTES  registered control word
- cw_valid  out  1  cw_out holds a real word
- irq_taken  out  1  one-cycle pulse on IRQ intercept
- stack_err  out  1  sticky stack over/underflow

Behaviour:
- Reset (sync, rst=1 at posedge), registers load:
  - uaddr=FETCH_ADDR, cw_out=0, cw_valid=0.
  - esc_q=0, irq_taken=0, stack pointer=0, stack_err=0.
  - rst has priority over stall.
- Fields decoded from rom_data (current word W at uaddr):
  - typ = bits 1:0.
  - off = bits 8:2, 7-bit two's complement.
  - cond_invert = bit 9; cond_flag_src = bit 10 (0 = cond_cpu, 1 = cond_u).
  - cond_sel = bits 14:11; escape = bit 15.
- Each non-stalled posedge, cw_out <= rom_data, cw_valid <= 1, and uaddr <= next:
  - typ 00 OFFSET: uaddr + 1 + sext(off).
  - typ 01 BRANCH: c = vec[cond_sel] ^ cond_invert; c=1 gives uaddr + 1 + sext(off), c=0 gives uaddr + 1.
  - typ 10 PREFETCH: FETCH_ADDR.
  - typ 11 DISPATCH:
    - irq_req & irq_en: IRQ_ADDR, irq_taken pulses 1.
    - otherwise: {esc_q, opcode, CYC_W'b0}; esc_q clears.
- All address arithmetic is modulo 2^UADDR_W (wraps; no error).
- Escape:
  - escape=1 in any non-stalled word sets esc_q.
  - esc_q is consumed by the next non-IRQ dispatch.
  - An IRQ dispatch leaves esc_q unchanged.
  - escape=1 on a dispatch word sets esc_q after the clear (set wins).
- Conditions are sampled in the cycle W is at uaddr, i.e. before W's datapath effects. Microcode must insert one word between a flag write and a branch on it.
- Stall=1: uaddr, cw_out, cw_valid, esc_q, stack and stack_err hold; irq_taken=0.
- irq_taken is 0 on every cycle without an intercept.

Optional Feature:
- Macro U_SEQ_STACK_EN.
- With the macro:
  - typ 01 with cond_sel 14 = CALL: push uaddr+1, jump uaddr+1+sext(off).
  - cond_sel 15 = RET: pop into uaddr.
  - Push when full: no push, jump still taken, stack_err <= 1.
  - Pop when empty: uaddr <= FETCH_ADDR, stack_err <= 1.
  - Stack is STACK_DEPTH x UADDR_W registers.
- Without the macro:
  - cond_sel 14/15 are ordinary conditions.
  - stack_err tied 0; no stack storage.

Decomposition:
- Shared package pa_useq:
  - typ encodings (TYP_OFFSET, TYP_BRANCH, TYP_PREFETCH, TYP_DISPATCH).
  - Field bit positions for typ, off, cond_invert, cond_flag_src, cond_sel, escape.
  - CALL_SEL=14, RET_SEL=15.
  - Packed struct for the 16-bit sequencing header.
- One natural sub-module, u_seq_stack: LIFO with push/pop/full/empty and err; instantiated only under U_SEQ_STACK_EN.

Test Plan:
- Reset mid-run: run 5 words, assert rst for 1 cycle -> uaddr=0, cw_valid=0, cw_out=0; next posedge cw_out=ROM[0], cw_valid=1.
- OFFSET: word at 0x010 with typ 00, off=-3 (0x7D) -> uaddr 0x00E; off=0 -> 0x011; word at 0x7FFF with off=0 -> wraps to 0x0000.
- BRANCH: cond_sel=3, src=cpu, cond_cpu[3]=1:
  - invert=0, off=5 at 0x020 -> 0x026.
  - invert=1 -> 0x021.
  - src=1 with cond_u[3]=0, invert=0 -> 0x021.
- DISPATCH with escape:
  - opcode 0xA5, esc_q=0 -> uaddr 0x2940.
  - A prior word with escape=1, then dispatch opcode 0x12 -> 0x4480, and esc_q is 0 afterwards.
- IRQ and stall:
  - Dispatch with irq_req=1, irq_en=1 -> uaddr 0x7FC0, irq_taken=1 for exactly 1 cycle.
  - irq_en=0 -> normal dispatch.
  - stall=1 for 3 cycles -> uaddr/cw_out unchanged.
- U_SEQ_STACK_EN:
  - CALL from 0x030 with off=0x10 -> 0x041; RET -> 0x031.
  - 5 CALLs with depth 4 -> stack_err=1 after the 5th.
  - RET when empty -> uaddr 0 and stack_err=1.

Source files
------------

// File: rtl/u_sequencer_pkg.sv
// Shared definitions for the microcode sequencer: sequencing-header layout,
// next-address type encodings and the call/return condition selectors.
package pa_useq;

   typedef enum logic [1:0] {
      TYP_OFFSET   = 2'b00,
      TYP_BRANCH   = 2'b01,
      TYP_PREFETCH = 2'b10,
      TYP_DISPATCH = 2'b11
   } typ_e;

   localparam int TYP_LSB       = 0;
   localparam int TYP_W         = 2;
   localparam int OFF_LSB       = 2;
   localparam int OFF_W         = 7;
   localparam int COND_INV_BIT  = 9;
   localparam int COND_SRC_BIT  = 10;
   localparam int COND_SEL_LSB  = 11;
   localparam int COND_SEL_W    = 4;
   localparam int ESCAPE_BIT    = 15;
   localparam int HDR_W         = 16;

   localparam logic [COND_SEL_W-1:0] CALL_SEL = 4'd14;
   localparam logic [COND_SEL_W-1:0] RET_SEL  = 4'd15;

   // Low 16 bits of every control word, most significant field first.
   typedef struct packed {
      logic                  escape;
      logic [COND_SEL_W-1:0] cond_sel;
      logic                  cond_flag_src;
      logic                  cond_invert;
      logic [OFF_W-1:0]      off;
      typ_e                  typ;
   } seq_hdr_t;

endpackage

// File: rtl/u_sequencer_stack.sv
// Return-address LIFO for the sequencer call/return extension.
// Overflowing pushes and underflowing pops are dropped and flag a sticky error.
module u_seq_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 15
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] push_data_i,
   output logic [W-1:0] top_o,
   output logic         empty_o,
   output logic         err_o
);

   localparam int SP_W  = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [SP_W-1:0]  sp_q, sp_d;
   logic             err_q, err_d;
   logic             full;
   logic [W-1:0]     mem_q [DEPTH];
   logic [IDX_W-1:0] wr_idx, rd_idx;

   assign full    = (sp_q == SP_W'(DEPTH));
   assign empty_o = (sp_q == '0);
   assign wr_idx  = IDX_W'(sp_q);
   assign rd_idx  = IDX_W'(sp_q - SP_W'(1));
   assign top_o   = mem_q[rd_idx];
   assign err_o   = err_q;

   always_comb begin
      sp_d  = sp_q;
      err_d = err_q;
      if (push_i) begin
         if (full) err_d = 1'b1;
         else      sp_d  = sp_q + SP_W'(1);
      end else if (pop_i) begin
         if (empty_o) err_d = 1'b1;
         else         sp_d  = sp_q - SP_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sp_q  <= '0;
         err_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         err_q <= err_d;
      end
   end

   // Entries need no reset: they are only read below the stack pointer.
   always_ff @(posedge clk_i) begin
      if (push_i && !full) mem_q[wr_idx] <= push_data_i;
   end

endmodule

// File: rtl/u_sequencer.sv
// Microcode sequencer: registers the micro-address and control word and forms the
// next address from the word header. Define U_SEQ_STACK_EN for call/return support.
module u_sequencer
   import pa_useq::*;
#(
   parameter  int CW_BYTES    = 14,
   parameter  int OPC_W       = 8,
   parameter  int CYC_W       = 6,
   parameter  int STACK_DEPTH = 4,
   parameter  int FETCH_ADDR  = 0,
   parameter  int IRQ_ADDR    = 'h7FC0,
   localparam int UADDR_W     = 1 + OPC_W + CYC_W,
   localparam int CW_W        = 8 * CW_BYTES
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               stall_i,
   input  logic [OPC_W-1:0]   opcode_i,
   input  logic [15:0]        cond_cpu_i,
   input  logic [15:0]        cond_u_i,
   input  logic               irq_req_i,
   input  logic               irq_en_i,
   output logic [UADDR_W-1:0] uaddr_o,
   input  logic [CW_W-1:0]    rom_data_i,
   output logic [CW_W-1:0]    cw_out_o,
   output logic               cw_valid_o,
   output logic               irq_taken_o,
   output logic               stack_err_o
);

   localparam logic [UADDR_W-1:0] FETCH_UA = UADDR_W'(FETCH_ADDR);
   localparam logic [UADDR_W-1:0] IRQ_UA   = UADDR_W'(IRQ_ADDR);

   if (CW_BYTES < 2 || STACK_DEPTH < 1) begin : g_param_check
      $error("u_sequencer: CW_BYTES must be >= 2 and STACK_DEPTH >= 1");
   end

   logic [UADDR_W-1:0] uaddr_q, uaddr_d;
   logic [CW_W-1:0]    cw_q, cw_d;
   logic               cw_valid_q, cw_valid_d;
   logic               esc_q, esc_d;
   logic               irq_taken_q, irq_taken_d;

   seq_hdr_t           hdr;
   logic [15:0]        cond_vec;
   logic               cond_hit;
   logic               irq_hit;
   logic [UADDR_W-1:0] off_ext;
   logic [UADDR_W-1:0] seq_addr;
   logic [UADDR_W-1:0] rel_addr;
   logic [UADDR_W-1:0] dispatch_addr;

   assign hdr           = seq_hdr_t'(rom_data_i[HDR_W-1:0]);
   assign cond_vec      = hdr.cond_flag_src ? cond_u_i : cond_cpu_i;
   assign cond_hit      = cond_vec[hdr.cond_sel] ^ hdr.cond_invert;
   assign irq_hit       = irq_req_i && irq_en_i;
   assign off_ext       = {{(UADDR_W-OFF_W){hdr.off[OFF_W-1]}}, hdr.off};
   assign seq_addr      = uaddr_q + UADDR_W'(1);
   assign rel_addr      = seq_addr + off_ext;
   assign dispatch_addr = {esc_q, opcode_i, {CYC_W{1'b0}}};

`ifdef U_SEQ_STACK_EN
   logic               is_call, is_ret;
   logic               stack_empty;
   logic [UADDR_W-1:0] stack_top;

   assign is_call = (hdr.typ == TYP_BRANCH) && (hdr.cond_sel == CALL_SEL);
   assign is_ret  = (hdr.typ == TYP_BRANCH) && (hdr.cond_sel == RET_SEL);

   u_seq_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (UADDR_W)
   ) u_stack (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (is_call && !stall_i),
      .pop_i       (is_ret && !stall_i),
      .push_data_i (seq_addr),
      .top_o       (stack_top),
      .empty_o     (stack_empty),
      .err_o       (stack_err_o)
   );
`else
   assign stack_err_o = 1'b0;
`endif

   always_comb begin
      uaddr_d     = uaddr_q;
      cw_d        = cw_q;
      cw_valid_d  = cw_valid_q;
      esc_d       = esc_q;
      irq_taken_d = 1'b0;
      if (!stall_i) begin
         cw_d       = rom_data_i;
         cw_valid_d = 1'b1;
         unique case (hdr.typ)
            TYP_OFFSET:   uaddr_d = rel_addr;
            TYP_BRANCH:   uaddr_d = cond_hit ? rel_addr : seq_addr;
            TYP_PREFETCH: uaddr_d = FETCH_UA;
            TYP_DISPATCH: begin
               // An intercepted dispatch keeps the escape page for the later re-dispatch.
               if (irq_hit) begin
                  uaddr_d     = IRQ_UA;
                  irq_taken_d = 1'b1;
               end else begin
                  uaddr_d = dispatch_addr;
                  esc_d   = 1'b0;
               end
            end
         endcase
`ifdef U_SEQ_STACK_EN
         if (is_call)     uaddr_d = rel_addr;
         else if (is_ret) uaddr_d = stack_empty ? FETCH_UA : stack_top;
`endif
         if (hdr.escape) esc_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         uaddr_q     <= FETCH_UA;
         cw_q        <= '0;
         cw_valid_q  <= 1'b0;
         esc_q       <= 1'b0;
         irq_taken_q <= 1'b0;
      end else begin
         uaddr_q     <= uaddr_d;
         cw_q        <= cw_d;
         cw_valid_q  <= cw_valid_d;
         esc_q       <= esc_d;
         irq_taken_q <= irq_taken_d;
      end
   end

   assign uaddr_o     = uaddr_q;
   assign cw_out_o    = cw_q;
   assign cw_valid_o  = cw_valid_q;
   assign irq_taken_o = irq_taken_q;

endmodule

// File: tb/tb_u_sequencer.sv
// Bench for u_sequencer: directed address cases plus a randomized run, all checked
// against an arithmetic reference model of the next-address rules.
module tb_u_sequencer;

   localparam int UADDR_W = 15;
   localparam int CW_W    = 112;
   localparam int MASK    = 32'h7FFF;
   localparam int FETCH   = 0;
   localparam int IRQ_A   = 32'h7FC0;
   localparam int DEPTH   = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              stall = 1'b0;
   logic [7:0]        opcode = '0;
   logic [15:0]       cond_cpu = '0;
   logic [15:0]       cond_u = '0;
   logic              irq_req = 1'b0;
   logic              irq_en = 1'b0;
   logic [UADDR_W-1:0] uaddr;
   logic [CW_W-1:0]   rom_data;
   logic [CW_W-1:0]   cw_out;
   logic              cw_valid, irq_taken, stack_err;

   logic [CW_W-1:0]   rom [0:32767];
   assign rom_data = rom[uaddr];

   always #5 clk = ~clk;

   u_sequencer dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .stall_i     (stall),
      .opcode_i    (opcode),
      .cond_cpu_i  (cond_cpu),
      .cond_u_i    (cond_u),
      .irq_req_i   (irq_req),
      .irq_en_i    (irq_en),
      .uaddr_o     (uaddr),
      .rom_data_i  (rom_data),
      .cw_out_o    (cw_out),
      .cw_valid_o  (cw_valid),
      .irq_taken_o (irq_taken),
      .stack_err_o (stack_err)
   );

   int            n_tests = 0;
   int            n_fail  = 0;

   int            m_ua    = 0;
   logic [CW_W-1:0] m_cw  = '0;
   bit            m_valid = 0;
   bit            m_esc   = 0;
   bit            m_irq   = 0;
   bit            m_err   = 0;
   int            m_stk[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CW_W-1:0] mk(input int typ, input int off, input bit inv,
                                          input bit src, input int sel, input bit esc);
      logic [127:0]    r;
      logic [CW_W-1:0] w;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      w = r[CW_W-1:0];
      w[15:0] = {esc, sel[3:0], src, inv, off[6:0], typ[1:0]};
      return w;
   endfunction

   // Advance the model by one clock using the current inputs, clock the DUT, compare.
   task automatic cycle();
      logic [CW_W-1:0] w;
      int typ, off, sel, nxt;
      bit c, src, inv, esc;
      if (rst) begin
         m_ua = FETCH; m_cw = '0; m_valid = 0; m_esc = 0; m_irq = 0; m_err = 0;
         m_stk.delete();
      end else if (stall) begin
         m_irq = 0;
      end else begin
         w   = rom[m_ua];
         typ = int'(w[1:0]);
         off = int'(w[8:2]);
         if (off > 63) off -= 128;
         inv = w[9];
         src = w[10];
         sel = int'(w[14:11]);
         esc = w[15];
         c   = (src ? cond_u[sel] : cond_cpu[sel]) ^ inv;
         m_irq = 0;
         nxt = m_ua + 1;
         case (typ)
            0: nxt = m_ua + 1 + off;
            1: begin
`ifdef U_SEQ_STACK_EN
               if (sel == 14) begin
                  if (m_stk.size() < DEPTH) m_stk.push_back((m_ua + 1) & MASK);
                  else m_err = 1;
                  nxt = m_ua + 1 + off;
               end else if (sel == 15) begin
                  if (m_stk.size() == 0) begin
                     nxt = FETCH; m_err = 1;
                  end else nxt = m_stk.pop_back();
               end else
`endif
               nxt = c ? (m_ua + 1 + off) : (m_ua + 1);
            end
            2: nxt = FETCH;
            default: begin
               if (irq_req && irq_en) begin
                  nxt = IRQ_A; m_irq = 1;
               end else begin
                  nxt = (int'(m_esc) << 14) | (int'(opcode) << 6);
                  m_esc = 0;
               end
            end
         endcase
         if (esc) m_esc = 1;
         m_ua = nxt & MASK;
         m_cw = w;
         m_valid = 1;
      end
      @(posedge clk);
      #1;
      chk("uaddr", uaddr, m_ua);
      chk("cw_out", cw_out, m_cw);
      chk("cw_valid", cw_valid, m_valid);
      chk("irq_taken", irq_taken, m_irq);
      chk("stack_err", stack_err, m_err);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) rom[i] = '0;

      do_reset();
      chk("reset_uaddr", uaddr, 0);
      chk("reset_valid", cw_valid, 0);

      // reset in the middle of a run
      for (int i = 0; i < 5; i++) rom[i] = mk(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle();
      chk("run5_uaddr", uaddr, 5);
      do_reset();
      chk("midrst_uaddr", uaddr, 0);
      chk("midrst_valid", cw_valid, 0);
      chk("midrst_cw", cw_out, 0);
      cycle();
      chk("post_rst_cw", cw_out, rom[0]);
      chk("post_rst_valid", cw_valid, 1);

      // OFFSET
      do_reset();
      rom[0]  = mk(0, 15, 0, 0, 0, 0);
      rom[16] = mk(0, -3, 0, 0, 0, 0);
      cycle(); chk("off_to_10", uaddr, 15'h010);
      cycle(); chk("off_neg3", uaddr, 15'h00E);
      do_reset();
      rom[16] = mk(0, 0, 0, 0, 0, 0);
      cycle(); cycle(); chk("off_zero", uaddr, 15'h011);
      do_reset();
      rom[0] = mk(0, 0, 0, 0, 0, 1);
      rom[1] = mk(3, 0, 0, 0, 0, 0);
      opcode = 8'hFF;
      cycle(); cycle(); chk("esc_disp_ff", uaddr, 15'h7FC0);
      rom[15'h7FC0] = mk(0, 62, 0, 0, 0, 0);
      rom[15'h7FFF] = mk(0, 0, 0, 0, 0, 0);
      cycle(); chk("to_7fff", uaddr, 15'h7FFF);
      cycle(); chk("wrap", uaddr, 15'h0000);

      // BRANCH
      cond_cpu = 16'h0008; cond_u = 16'h0000;
      do_reset();
      rom[0]  = mk(0, 31, 0, 0, 0, 0);
      rom[32] = mk(1, 5, 0, 0, 3, 0);
      cycle(); chk("to_20", uaddr, 15'h020);
      cycle(); chk("br_taken", uaddr, 15'h026);
      do_reset();
      rom[32] = mk(1, 5, 1, 0, 3, 0);
      cycle(); cycle(); chk("br_inv", uaddr, 15'h021);
      do_reset();
      rom[32] = mk(1, 5, 0, 1, 3, 0);
      cycle(); cycle(); chk("br_ucond", uaddr, 15'h021);

      // DISPATCH and escape
      do_reset();
      rom[0] = mk(3, 0, 0, 0, 0, 0);
      opcode = 8'hA5;
      cycle(); chk("disp_a5", uaddr, 15'h2940);
      do_reset();
      rom[0] = mk(0, 0, 0, 0, 0, 1);
      rom[1] = mk(3, 0, 0, 0, 0, 0);
      opcode = 8'h12;
      cycle(); cycle(); chk("disp_esc", uaddr, 15'h4480);
      rom[15'h4480] = mk(3, 0, 0, 0, 0, 0);
      cycle(); chk("esc_cleared", uaddr, 15'h0480);
      do_reset();
      rom[0] = mk(3, 0, 0, 0, 0, 1);
      opcode = 8'h01;
      cycle(); chk("disp_setesc", uaddr, 15'h0040);
      rom[15'h0040] = mk(3, 0, 0, 0, 0, 0);
      opcode = 8'h02;
      cycle(); chk("esc_set_wins", uaddr, 15'h4080);

      // IRQ intercept
      do_reset();
      rom[0] = mk(3, 0, 0, 0, 0, 0);
      opcode = 8'hA5; irq_req = 1'b1; irq_en = 1'b1;
      cycle(); chk("irq_addr", uaddr, 15'h7FC0); chk("irq_pulse", irq_taken, 1);
      cycle(); chk("irq_one_cycle", irq_taken, 0);
      do_reset();
      irq_en = 1'b0;
      cycle(); chk("irq_masked", uaddr, 15'h2940); chk("irq_masked_pulse", irq_taken, 0);
      do_reset();
      rom[0] = mk(0, 0, 0, 0, 0, 1);
      rom[1] = mk(3, 0, 0, 0, 0, 0);
      irq_en = 1'b1;
      cycle(); cycle(); chk("irq_esc_addr", uaddr, 15'h7FC0);
      irq_req = 1'b0;
      rom[15'h7FC0] = mk(3, 0, 0, 0, 0, 0);
      opcode = 8'h12;
      cycle(); chk("irq_keeps_esc", uaddr, 15'h4480);

      // stall
      do_reset();
      rom[0]  = mk(0, 15, 0, 0, 0, 0);
      rom[16] = mk(0, -3, 0, 0, 0, 0);
      cycle();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle(); chk("stall_hold", uaddr, 15'h010);
      end
      stall = 1'b0;
      cycle(); chk("stall_release", uaddr, 15'h00E);

`ifdef U_SEQ_STACK_EN
      do_reset();
      rom[0]     = mk(0, 47, 0, 0, 0, 0);
      rom[16'h30] = mk(1, 16, 0, 0, 14, 0);
      rom[16'h41] = mk(1, 0, 0, 0, 15, 0);
      cycle(); chk("to_30", uaddr, 15'h030);
      cycle(); chk("call", uaddr, 15'h041);
      cycle(); chk("ret", uaddr, 15'h031); chk("ret_noerr", stack_err, 0);
      do_reset();
      for (int i = 0; i < 5; i++) rom[i] = mk(1, 0, 0, 0, 14, 0);
      for (int i = 0; i < 4; i++) cycle();
      chk("push4_noerr", stack_err, 0);
      cycle(); chk("push5_err", stack_err, 1); chk("push5_jump", uaddr, 5);
      do_reset();
      rom[0] = mk(1, 0, 0, 0, 15, 0);
      cycle(); chk("pop_empty_addr", uaddr, 0); chk("pop_empty_err", stack_err, 1);
`else
      do_reset();
      cond_cpu = 16'h4000;
      rom[0] = mk(1, 9, 0, 0, 14, 0);
      cycle(); chk("sel14_cond", uaddr, 15'h00A); chk("no_stack_err", stack_err, 0);
`endif

      // randomized run against the model
      for (int i = 0; i < 32768; i++) rom[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rst      = ($urandom_range(0, 99) == 0);
         stall    = ($urandom_range(0, 7) == 0);
         opcode   = 8'($urandom());
         cond_cpu = 16'($urandom());
         cond_u   = 16'($urandom());
         irq_req  = ($urandom_range(0, 3) == 0);
         irq_en   = 1'($urandom());
         cycle();
      end
      rst = 1'b0; stall = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
